// File: rtl/prog_loader_pkg.sv
// -----------------------------------------------------------------------------
// prog_loader_pkg
// Shared definitions for the program loader: FSM state encoding, stream
// framing constants and the checksum update helper.
// -----------------------------------------------------------------------------
package prog_loader_pkg;

  // Loader FSM states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_DATA = 3'd2,
    ST_CHK  = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_e;

  // Stream framing
  localparam int HDR_BYTES  = 2;   // word count N, MSB first
  localparam int WORD_BYTES = 4;   // bytes per instruction word, MSB first
  localparam int BYTE_W     = 8;
  localparam int WORD_W     = WORD_BYTES * BYTE_W;
  localparam int CHK_W      = 8;   // checksum width (XOR of word bytes)

  // Running checksum: XOR of every word byte
  function automatic logic [CHK_W-1:0] chk_update(input logic [CHK_W-1:0]  acc,
                                                  input logic [BYTE_W-1:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// -----------------------------------------------------------------------------
// prog_loader_if
// Groups the byte-stream handshake and the instruction-memory write bus.
//   s_valid/s_data/s_ready : byte stream into the loader (valid/ready)
//   imem_we/addr/wdata     : word write port toward instruction memory
// Modports:
//   slave  - the loader (consumes the stream, drives the memory bus)
//   master - the environment (drives the stream, observes the memory bus)
// -----------------------------------------------------------------------------
interface prog_loader_if #(
  parameter int ADDR_W = 8
) ();
  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport slave (
    input  s_valid, s_data,
    output s_ready, imem_we, imem_addr, imem_wdata
  );

  modport master (
    output s_valid, s_data,
    input  s_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/prog_loader_word_assembler.sv
// -----------------------------------------------------------------------------
// word_assembler
// Collects WORD_BYTES stream bytes MSB first into one word.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   clr_i         : synchronous clear, discards any partial word
//   byte_en_i     : a data byte transfers this cycle
//   byte_i        : the byte
//   last_byte_o   : combinational, this transfer completes a word
//   word_ready_o  : registered, high for one cycle after a word completes
//   word_o        : the completed word (held until the next one completes)
// -----------------------------------------------------------------------------
module word_assembler
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              byte_en_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic              last_byte_o,
  output logic              word_ready_o,
  output logic [WORD_W-1:0] word_o
);

  localparam int CNT_W = $clog2(WORD_BYTES);
  localparam int SH_W  = (WORD_BYTES - 1) * BYTE_W;

  logic [CNT_W-1:0]  cnt_q;
  logic [SH_W-1:0]   sh_q;
  logic [WORD_W-1:0] word_q;
  logic              ready_q;

  assign last_byte_o  = byte_en_i && (cnt_q == CNT_W'(WORD_BYTES - 1));
  assign word_ready_o = ready_q;
  assign word_o       = word_q;

  // The completed word is captured into its own register so the shift
  // register can take the first byte of the next word in the very cycle the
  // memory write is presented; this keeps the stream at one byte per cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      sh_q    <= '0;
      word_q  <= '0;
      ready_q <= 1'b0;
    end else if (clr_i) begin
      cnt_q   <= '0;
      sh_q    <= '0;
      word_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= last_byte_o;
      if (byte_en_i) begin
        cnt_q <= cnt_q + CNT_W'(1);
        sh_q  <= {sh_q[SH_W-BYTE_W-1:0], byte_i};
      end
      if (last_byte_o) begin
        word_q <= {sh_q, byte_i};
      end
    end
  end

endmodule

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
// Loads a program from a byte stream into instruction memory and releases the
// processor reset once the checksum verifies.
// Stream: N (2 bytes, MSB first), N words of 4 bytes (MSB first), then one
// checksum byte equal to the XOR of all word bytes.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   start      : load request pulse, honoured in IDLE, DONE and ERR
//   bus        : stream handshake in, instruction-memory write bus out
//   cpu_rst    : processor reset, high unless a verified program is loaded
//   done / err : load verified / load aborted
//   word_count : words written during the current load
// -----------------------------------------------------------------------------
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  prog_loader_if.slave    bus,
  output logic            cpu_rst,
  output logic            done,
  output logic            err,
  output logic [ADDR_W:0] word_count
);

  localparam int                HDR_CNT_W = (HDR_BYTES > 1) ? $clog2(HDR_BYTES) : 1;
  localparam logic [16:0]       DEPTH_X   = 17'(DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_MAX  = ADDR_W'(DEPTH - 1);

  state_e state_q, state_d;

  logic s_ready_q, s_ready_d;
  logic cpu_rst_q, cpu_rst_d;
  logic done_q, done_d;
  logic err_q, err_d;

  logic [HDR_CNT_W-1:0] hdr_cnt_q;
  logic [15:0]          n_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [ADDR_W:0]      wcnt_q;
  logic [CHK_W-1:0]     chk_q;

  logic              xfer;
  logic              load_start;
  logic              hdr_last;
  logic [15:0]       n_hdr;
  logic              data_byte;
  logic              last_byte;
  logic              last_word;
  logic              word_ready;
  logic [WORD_W-1:0] word;

  assign xfer       = s_ready_q && bus.s_valid;
  assign load_start = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                                (state_q == ST_ERR));
  assign hdr_last   = (state_q == ST_HDR) && xfer &&
                      (hdr_cnt_q == HDR_CNT_W'(HDR_BYTES - 1));
  // Word count including the header byte transferring right now
  assign n_hdr      = {n_q[7:0], bus.s_data};
  assign data_byte  = (state_q == ST_DATA) && xfer;
  // The previous word's write lands at least three cycles before this word's
  // last byte, so wcnt_q already equals the index of the word in flight.
  assign last_word  = (17'(wcnt_q) + 17'd1) == {1'b0, n_q};

  word_assembler u_asm (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (load_start),
    .byte_en_i    (data_byte),
    .byte_i       (bus.s_data),
    .last_byte_o  (last_byte),
    .word_ready_o (word_ready),
    .word_o       (word)
  );

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      s_ready_q <= 1'b0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_ready_q <= s_ready_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // --------------------------------------------------------------- next state
  // DATA moves to CHK on the last byte of the last word, so the write of that
  // word coincides with the first CHK cycle and the checksum byte that may
  // follow back-to-back is never mistaken for data.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) state_d = ST_HDR;
      end
      ST_HDR: begin
        if (hdr_last) begin
          if ({1'b0, n_hdr} > DEPTH_X) state_d = ST_ERR;
          else if (n_hdr == 16'd0)     state_d = ST_CHK;
          else                         state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (last_byte && last_word) state_d = ST_CHK;
      end
      ST_CHK: begin
        if (xfer) state_d = (bus.s_data == chk_q) ? ST_DONE : ST_ERR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------------ outputs
  // Outputs are registered copies of decodes of the next state, so s_ready is
  // glitch-free and already valid in the first cycle of each state.
  always_comb begin
    s_ready_d = (state_d == ST_HDR) || (state_d == ST_DATA) || (state_d == ST_CHK);
    done_d    = (state_d == ST_DONE);
    err_d     = (state_d == ST_ERR);
    cpu_rst_d = (state_d != ST_DONE);
  end

  // ----------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hdr_cnt_q <= '0;
      n_q       <= '0;
      addr_q    <= '0;
      wcnt_q    <= '0;
      chk_q     <= '0;
    end else if (load_start) begin
      hdr_cnt_q <= '0;
      n_q       <= '0;
      addr_q    <= '0;
      wcnt_q    <= '0;
      chk_q     <= '0;
    end else begin
      if ((state_q == ST_HDR) && xfer) begin
        hdr_cnt_q <= hdr_cnt_q + HDR_CNT_W'(1);
        n_q       <= n_hdr;
      end
      if (data_byte) begin
        chk_q <= chk_update(chk_q, bus.s_data);
      end
      if (word_ready) begin
        wcnt_q <= wcnt_q + 1'b1;
        // Hold at the top address so a full-depth load never points past it
        if (addr_q != ADDR_MAX) addr_q <= addr_q + 1'b1;
      end
    end
  end

  assign bus.s_ready    = s_ready_q;
  assign bus.imem_we    = word_ready;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = word;
  assign cpu_rst        = cpu_rst_q;
  assign done           = done_q;
  assign err            = err_q;
  assign word_count     = wcnt_q;

endmodule

// File: tb/tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_loader
// Directed bench for prog_loader. Expected memory writes are queued when the
// stream is driven and matched by a write monitor; status outputs are checked
// at fixed points in the directed sequence.
// -----------------------------------------------------------------------------
module tb_prog_loader;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       cpu_rst, done, err;
  logic [8:0] word_count;

  int   errors = 0;
  int   checks = 0;
  wr_t  exp_q[$];
  wr_t  mon_e;
  bit   gap_en = 1'b0;
  logic [7:0] tb_chk;

  prog_loader_if #(.ADDR_W(8)) bus ();

  prog_loader #(.DEPTH(256), .ADDR_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bus        (bus),
    .cpu_rst    (cpu_rst),
    .done       (done),
    .err        (err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish by 500000, required finish");
    $fatal(1, "watchdog expired");
  end

  // Write monitor: every imem_we cycle must match the head of the scoreboard
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write: observed addr %0d data %h, required no write",
               bus.imem_addr, bus.imem_wdata);
      end
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        checks++;
        assert ({bus.imem_addr, bus.imem_wdata} === {mon_e.addr, mon_e.data}) else begin
          errors++;
          $error("FAIL write: observed addr %0d data %h, required addr %0d data %h",
                 bus.imem_addr, bus.imem_wdata, mon_e.addr, mon_e.data);
        end
      end
      $display("write addr=%0d data=%h", bus.imem_addr, bus.imem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h, required %h", tag, obs, exp);
    end
  endtask

  // Present one byte and return #1 after the edge that transfers it
  task automatic send_byte(input logic [7:0] b);
    int n;
    int k;
    n = 0;
    if (gap_en) begin
      k = $urandom_range(0, 3);
      if (k > 0) begin
        bus.s_valid = 1'b0;
        repeat (k) @(negedge clk);
      end
    end
    bus.s_valid = 1'b1;
    bus.s_data  = b;
    while (bus.s_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_ready: observed s_ready %b after 50 cycles, required 1", bus.s_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) begin
      send_byte(w[8*i +: 8]);
      tb_chk = tb_chk ^ w[8*i +: 8];
    end
  endtask

  task automatic push_wr(input logic [7:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic pulse_start();
    bus.s_valid = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Nominal three-word program, queued and streamed
  task automatic nominal(input logic [7:0] cks);
    push_wr(8'd0, 32'h20080005);
    push_wr(8'd1, 32'h2009000A);
    push_wr(8'd2, 32'h01095020);
    tb_chk = 8'h00;
    send_byte(8'h00);
    send_byte(8'h03);
    send_word(32'h20080005);
    send_word(32'h2009000A);
    send_word(32'h01095020);
    send_byte(cks);
    bus.s_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    logic [7:0]  ib;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;

    // ---- reset state
    #12;
    check("rst_s_ready", 32'(bus.s_ready), 32'd0);
    check("rst_imem_we", 32'(bus.imem_we), 32'd0);
    check("rst_imem_addr", 32'(bus.imem_addr), 32'd0);
    check("rst_imem_wdata", bus.imem_wdata, 32'd0);
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_rst_s_ready", 32'(bus.s_ready), 32'd0);
    check("idle_after_rst_cpu_rst", 32'(cpu_rst), 32'd1);
    $display("txn reset: done");

    // ---- nominal load
    pulse_start();
    check("nom_start_s_ready", 32'(bus.s_ready), 32'd1);
    check("nom_start_cpu_rst", 32'(cpu_rst), 32'd1);
    nominal(8'h76);
    check("nom_done", 32'(done), 32'd1);
    check("nom_err", 32'(err), 32'd0);
    check("nom_cpu_rst", 32'(cpu_rst), 32'd0);
    check("nom_word_count", 32'(word_count), 32'd3);
    check("nom_s_ready", 32'(bus.s_ready), 32'd0);
    check("nom_writes_left", 32'(exp_q.size()), 32'd0);
    $display("txn nominal: done=%0d word_count=%0d", done, word_count);

    // ---- bad checksum
    pulse_start();
    check("bad_start_done", 32'(done), 32'd0);
    check("bad_start_cpu_rst", 32'(cpu_rst), 32'd1);
    check("bad_start_word_count", 32'(word_count), 32'd0);
    nominal(8'h77);
    check("bad_err", 32'(err), 32'd1);
    check("bad_done", 32'(done), 32'd0);
    check("bad_cpu_rst", 32'(cpu_rst), 32'd1);
    check("bad_word_count", 32'(word_count), 32'd3);
    check("bad_writes_left", 32'(exp_q.size()), 32'd0);
    $display("txn bad_checksum: err=%0d", err);

    // ---- oversize header N = 257
    pulse_start();
    check("big_start_err", 32'(err), 32'd0);
    send_byte(8'h01);
    send_byte(8'h01);
    bus.s_valid = 1'b0;
    check("big_err", 32'(err), 32'd1);
    check("big_s_ready", 32'(bus.s_ready), 32'd0);
    repeat (4) @(negedge clk);
    check("big_err_hold", 32'(err), 32'd1);
    check("big_s_ready_hold", 32'(bus.s_ready), 32'd0);
    check("big_word_count", 32'(word_count), 32'd0);
    $display("txn oversize: err=%0d", err);

    // ---- N = 0, with an ignored start pulse in the middle of the header
    pulse_start();
    send_byte(8'h00);
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h00);
    bus.s_valid = 1'b0;
    check("zero_done", 32'(done), 32'd1);
    check("zero_word_count", 32'(word_count), 32'd0);
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h01);
    bus.s_valid = 1'b0;
    check("zero_bad_err", 32'(err), 32'd1);
    check("zero_bad_done", 32'(done), 32'd0);
    $display("txn zero_len: err=%0d", err);

    // ---- full-depth load, 256 words
    pulse_start();
    tb_chk = 8'h00;
    send_byte(8'h01);
    send_byte(8'h00);
    for (int i = 0; i < 256; i++) begin
      ib = i[7:0];
      w  = {ib, ~ib, 8'h5A, ib ^ 8'h33};
      push_wr(ib, w);
      send_word(w);
    end
    send_byte(tb_chk);
    bus.s_valid = 1'b0;
    check("full_done", 32'(done), 32'd1);
    check("full_word_count", 32'(word_count), 32'd256);
    check("full_addr_max", 32'(bus.imem_addr), 32'd255);
    check("full_writes_left", 32'(exp_q.size()), 32'd0);
    $display("txn full_depth: word_count=%0d", word_count);

    // ---- nominal with random s_valid gaps
    gap_en = 1'b1;
    pulse_start();
    nominal(8'h76);
    check("gap_done", 32'(done), 32'd1);
    check("gap_word_count", 32'(word_count), 32'd3);
    check("gap_writes_left", 32'(exp_q.size()), 32'd0);
    gap_en = 1'b0;
    $display("txn gapped_nominal: done=%0d", done);

    // ---- reload one word from DONE
    pulse_start();
    check("reload_cpu_rst", 32'(cpu_rst), 32'd1);
    check("reload_done_clr", 32'(done), 32'd0);
    push_wr(8'd0, 32'h00000008);
    tb_chk = 8'h00;
    send_byte(8'h00);
    send_byte(8'h01);
    send_word(32'h00000008);
    send_byte(8'h08);
    bus.s_valid = 1'b0;
    check("reload_done", 32'(done), 32'd1);
    check("reload_cpu_rst_rel", 32'(cpu_rst), 32'd0);
    check("reload_word_count", 32'(word_count), 32'd1);
    check("reload_writes_left", 32'(exp_q.size()), 32'd0);
    $display("txn reload: done=%0d", done);

    // ---- gapped load aborted by reset after byte 7
    gap_en = 1'b1;
    pulse_start();
    push_wr(8'd0, 32'h20080005);
    send_byte(8'h00);
    send_byte(8'h03);
    send_word(32'h20080005);
    send_byte(8'h20);
    rst = 1'b0;
    #1;
    check("abort_s_ready", 32'(bus.s_ready), 32'd0);
    check("abort_imem_we", 32'(bus.imem_we), 32'd0);
    check("abort_cpu_rst", 32'(cpu_rst), 32'd1);
    check("abort_addr", 32'(bus.imem_addr), 32'd0);
    check("abort_word_count", 32'(word_count), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    bus.s_valid = 1'b0;
    gap_en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_idle_s_ready", 32'(bus.s_ready), 32'd0);
    check("abort_idle_cpu_rst", 32'(cpu_rst), 32'd1);
    check("abort_writes_left", 32'(exp_q.size()), 32'd0);
    $display("txn reset_abort: cpu_rst=%0d", cpu_rst);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
